seg_scan_decoder: RTL and testbench

- Receive-side counterpart of the 4-digit multiplexed 7-segment driver.
- Samples the scanned wei/seg lines and decodes each segment pattern back to a 4-bit value.
- Assembles complete 4-digit frames and presents them with a one-cycle valid strobe.
- Used in self-checking benches and on-board loopback to confirm that the displayed digits match the source data.

---
 rtl/seg_scan_decoder.sv | 235 +++++++++++++++++++++++
 tb/tb_seg_scan_decoder.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder
//   Receive-side decoder for a 4-digit multiplexed 7-segment display.
//   It samples the scanned digit-select (wei) and segment (seg) lines and
//   waits until each one-hot digit has been stable for STABLE_CYC samples.
//   It then decodes the segment pattern back to a hex nibble. When all four
//   digits have been captured, it presents them as one frame together with
//   a single-cycle frame_valid strobe.
//
// Ports:
//   clk          in   system clock, rising edge
//   rst          in   asynchronous reset, active low
//   wei[3:0]     in   digit select from the display driver, bit n = digit n
//   seg[6:0]     in   segment lines {g,f,e,d,c,b,a}
//   data0..3     out  decoded digits of the last complete frame
//   frame_valid  out  one-cycle pulse when data0..3 update
//   frame_err    out  last frame held at least one undecodable pattern
//   stalled      out  no capture for TIMEOUT_CYC cycles; cleared by a capture
//   changed      out  (only with SEG_SCAN_CHANGE_EN) pulses with frame_valid
//                     when the new frame differs from the previous one
//
// Build option: define SEG_SCAN_CHANGE_EN to add the 'changed' output.
module seg_scan_decoder #(
    parameter int STABLE_CYC     = 8,
    parameter int TIMEOUT_CYC    = 65536,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit WEI_ACTIVE_LOW = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] wei,
    input  logic [6:0] seg,
    output logic [3:0] data0,
    output logic [3:0] data1,
    output logic [3:0] data2,
    output logic [3:0] data3,
    output logic       frame_valid,
    output logic       frame_err,
`ifdef SEG_SCAN_CHANGE_EN
    output logic       changed,
`endif
    output logic       stalled
);

    localparam int CNT_W  = $clog2(STABLE_CYC + 1);
    localparam int IDLE_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(STABLE_CYC - 1);
    localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(STABLE_CYC);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYC - 1);
    localparam logic [IDLE_W-1:0] IDLE_MAX  = IDLE_W'(TIMEOUT_CYC);

    typedef enum logic [1:0] {S_IDLE, S_DWELL, S_CAPTURED} state_t;

    // Returns {invalid, value}; unknown patterns decode to 0 with invalid set.
    function automatic logic [4:0] f_decode(input logic [6:0] p);
        case (p)
            7'h3F: return 5'h00;
            7'h06: return 5'h01;
            7'h5B: return 5'h02;
            7'h4F: return 5'h03;
            7'h66: return 5'h04;
            7'h6D: return 5'h05;
            7'h7D: return 5'h06;
            7'h07: return 5'h07;
            7'h7F: return 5'h08;
            7'h6F: return 5'h09;
            7'h77: return 5'h0A;
            7'h7C: return 5'h0B;
            7'h39: return 5'h0C;
            7'h5E: return 5'h0D;
            7'h79: return 5'h0E;
            7'h71: return 5'h0F;
            default: return 5'h10;
        endcase
    endfunction

    logic [3:0]        r_wei_s1, r_wei_s2;
    logic [6:0]        r_seg_s1, r_seg_s2;
    logic [10:0]       r_prev;
    state_t            r_state, w_state_nxt;
    logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
    logic [IDLE_W-1:0] r_idle;
    logic [15:0]       r_shadow;
    logic [3:0]        r_seen, r_err, w_seen_nxt, w_err_nxt;
    logic [15:0]       r_data;
    logic              r_fv, r_ferr, r_stalled;

    logic [3:0]        w_wei_n;
    logic [6:0]        w_seg_n;
    logic              w_onehot, w_same, w_capture, w_complete, w_timeout;
    logic [1:0]        w_idx;
    logic [4:0]        w_dec;

    assign w_wei_n    = WEI_ACTIVE_LOW ? ~r_wei_s2 : r_wei_s2;
    assign w_seg_n    = SEG_ACTIVE_LOW ? ~r_seg_s2 : r_seg_s2;
    assign w_onehot   = (w_wei_n != 4'd0) && ((w_wei_n & (w_wei_n - 4'd1)) == 4'd0);
    assign w_same     = ({w_wei_n, w_seg_n} == r_prev);
    assign w_dec      = f_decode(w_seg_n);
    assign w_complete = (r_seen == 4'hF);
    // A capture in the same cycle pre-empts the timeout.
    assign w_timeout  = !w_capture && (r_idle == IDLE_LAST);

    always_comb begin
        case (w_wei_n)
            4'b0010: w_idx = 2'd1;
            4'b0100: w_idx = 2'd2;
            4'b1000: w_idx = 2'd3;
            default: w_idx = 2'd0;
        endcase
    end

    // The counter holds the number of consecutive identical samples seen.
    // Reaching STABLE_CYC is the capture point.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_capture   = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_cnt_nxt = '0;
                if (w_onehot) begin
                    w_state_nxt = S_DWELL;
                    w_cnt_nxt   = CNT_ONE;
                end
            end
            S_DWELL: begin
                if (!w_same) begin
                    w_state_nxt = w_onehot ? S_DWELL : S_IDLE;
                    w_cnt_nxt   = w_onehot ? CNT_ONE : '0;
                end else if (r_cnt == CNT_LAST) begin
                    w_capture   = 1'b1;
                    w_state_nxt = S_CAPTURED;
                    w_cnt_nxt   = CNT_FULL;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_ONE;
                end
            end
            S_CAPTURED: begin
                if (!w_same) begin
                    w_state_nxt = w_onehot ? S_DWELL : S_IDLE;
                    w_cnt_nxt   = w_onehot ? CNT_ONE : '0;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Frame completion and timeout both discard the slot bookkeeping. A new
    // capture is applied on top, so it is never lost.
    always_comb begin
        w_seen_nxt = r_seen;
        w_err_nxt  = r_err;
        if (w_complete || w_timeout) begin
            w_seen_nxt = 4'd0;
            w_err_nxt  = 4'd0;
        end
        if (w_capture) begin
            w_seen_nxt[w_idx] = 1'b1;
            w_err_nxt[w_idx]  = w_dec[4];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wei_s1  <= '0;
            r_wei_s2  <= '0;
            r_seg_s1  <= '0;
            r_seg_s2  <= '0;
            r_prev    <= '0;
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_idle    <= '0;
            r_shadow  <= '0;
            r_seen    <= '0;
            r_err     <= '0;
            r_data    <= '0;
            r_fv      <= 1'b0;
            r_ferr    <= 1'b0;
            r_stalled <= 1'b0;
        end else begin
            r_wei_s1 <= wei;
            r_wei_s2 <= r_wei_s1;
            r_seg_s1 <= seg;
            r_seg_s2 <= r_seg_s1;
            r_prev   <= {w_wei_n, w_seg_n};
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_seen   <= w_seen_nxt;
            r_err    <= w_err_nxt;
            if (w_capture) begin
                r_shadow[{w_idx, 2'b00} +: 4] <= w_dec[3:0];
            end
            if (w_capture) begin
                r_idle <= '0;
            end else if (r_idle != IDLE_MAX) begin
                r_idle <= r_idle + 1'b1;
            end
            if (w_capture) begin
                r_stalled <= 1'b0;
            end else if (w_timeout) begin
                r_stalled <= 1'b1;
            end
            r_fv <= w_complete;
            if (w_complete) begin
                r_data <= r_shadow;
                r_ferr <= |r_err;
            end
        end
    end

`ifdef SEG_SCAN_CHANGE_EN
    logic r_changed;
    // r_data resets to 0, so the first frame is compared against zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_changed <= 1'b0;
        end else begin
            r_changed <= w_complete && (r_shadow != r_data);
        end
    end
    assign changed = r_changed;
`endif

    assign data0       = r_data[3:0];
    assign data1       = r_data[7:4];
    assign data2       = r_data[11:8];
    assign data3       = r_data[15:12];
    assign frame_valid = r_fv;
    assign frame_err   = r_ferr;
    assign stalled     = r_stalled;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Testbench for seg_scan_decoder. Directed scans push expected frames into
// a queue. A monitor thread pops and compares on every frame_valid.
module tb_seg_scan_decoder;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] wei;
    logic [6:0] seg;
    logic [3:0] data0, data1, data2, data3;
    logic       frame_valid, frame_err, stalled;
`ifdef SEG_SCAN_CHANGE_EN
    logic       changed;
`endif

    always #5 clk = ~clk;

    seg_scan_decoder #(
        .STABLE_CYC    (8),
        .TIMEOUT_CYC   (100),
        .SEG_ACTIVE_LOW(1'b1),
        .WEI_ACTIVE_LOW(1'b1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .wei        (wei),
        .seg        (seg),
        .data0      (data0),
        .data1      (data1),
        .data2      (data2),
        .data3      (data3),
        .frame_valid(frame_valid),
        .frame_err  (frame_err),
`ifdef SEG_SCAN_CHANGE_EN
        .changed    (changed),
`endif
        .stalled    (stalled)
    );

    typedef struct {
        logic [15:0] data;
        logic        err;
        logic        chg;
    } exp_t;

    exp_t        sbq[$];
    exp_t        mon_e;
    logic [15:0] last_frame;
    int          n_vec = 0;
    int          n_err = 0;

    // Active-high gfedcba patterns for the hex digits.
    function automatic logic [6:0] pat(input int v);
        case (v)
            0: return 7'h3F;  1: return 7'h06;  2: return 7'h5B;  3: return 7'h4F;
            4: return 7'h66;  5: return 7'h6D;  6: return 7'h7D;  7: return 7'h07;
            8: return 7'h7F;  9: return 7'h6F; 10: return 7'h77; 11: return 7'h7C;
            12: return 7'h39; 13: return 7'h5E; 14: return 7'h79; default: return 7'h71;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic push_frame(input logic [3:0] d0, input logic [3:0] d1,
                              input logic [3:0] d2, input logic [3:0] d3,
                              input logic e);
        exp_t x;
        x.data = {d3, d2, d1, d0};
        x.err  = e;
        x.chg  = (x.data != last_frame);
        last_frame = x.data;
        sbq.push_back(x);
    endtask

    // Drives one digit with an active-high pattern for cyc cycles, then blanks for 2 cycles.
    task automatic scan_pat(input int d, input logic [6:0] p, input int cyc);
        wei = ~(4'b0001 << d);
        seg = ~p;
        repeat (cyc) @(posedge clk);
        #1;
        wei = 4'hF;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic scan(input int d, input int v);
        scan_pat(d, pat(v), 20);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain(input string name);
        idle(5);
        chk(name, sbq.size(), 0);
    endtask

    initial begin
        rst = 1'b0;
        wei = 4'hF;
        seg = 7'h7F;
        last_frame = 16'h0;

        fork
            forever begin
                @(negedge clk);
                if (frame_valid === 1'b1) begin
                    if (sbq.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL unexpected_frame: got frame_valid=1 data=%h%h%h%h, expected none",
                                 data3, data2, data1, data0);
                    end else begin
                        mon_e = sbq.pop_front();
                        chk("frame_data", {data3, data2, data1, data0}, mon_e.data);
                        chk("frame_err", frame_err, mon_e.err);
                        chk("frame_stalled", stalled, 1'b0);
`ifdef SEG_SCAN_CHANGE_EN
                        chk("frame_changed", changed, mon_e.chg);
`endif
                    end
                end
            end
        join_none

        // Reset state
        repeat (3) @(negedge clk);
        chk("reset_data", {data3, data2, data1, data0}, 16'h0);
        chk("reset_valid", frame_valid, 1'b0);
        chk("reset_err", frame_err, 1'b0);
        chk("reset_stalled", stalled, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        idle(3);

        // Basic frame 1,2,3,4
        push_frame(4'h1, 4'h2, 4'h3, 4'h4, 1'b0);
        scan(0, 1); scan(1, 2); scan(2, 3); scan(3, 4);
        drain("basic_pending");

        // Glitching digit 3 must not capture; the steady 8 afterwards does
        scan(0, 7); scan(1, 10); scan(2, 12);
        wei = 4'b0111;
        for (int k = 0; k < 10; k++) begin
            seg = ~pat((k % 2) ? 3 : 8);
            idle(3);
        end
        push_frame(4'h7, 4'hA, 4'hC, 4'h8, 1'b0);
        scan(3, 8);
        drain("glitch_pending");

        // Digit 1 scanned twice; the later value wins, a single frame results
        push_frame(4'hA, 4'h9, 4'hC, 4'hF, 1'b0);
        scan(0, 10); scan(1, 3); scan(1, 9); scan(2, 12); scan(3, 15);
        drain("repeat_pending");

        // Timeout discards the partial frame and raises stalled
        scan(0, 1); scan(1, 2);
        idle(60);
        chk("stall_early", stalled, 1'b0);
        idle(50);
        chk("stall_set", stalled, 1'b1);
        chk("stall_keep_data", {data3, data2, data1, data0}, 16'hFC9A);
        scan(2, 11);
        chk("stall_cleared", stalled, 1'b0);
        scan(3, 6);
        push_frame(4'hD, 4'hE, 4'hB, 4'h6, 1'b0);
        scan(0, 13); scan(1, 14);
        drain("stall_pending");

        // Undecodable pattern on digit 2
        push_frame(4'h5, 4'h6, 4'h0, 4'h7, 1'b1);
        scan(0, 5); scan(1, 6); scan_pat(2, 7'h00, 20); scan(3, 7);
        drain("invalid_pending");

        // Reset after the third capture discards the partial frame
        scan(0, 2); scan(1, 4); scan(2, 6);
        rst = 1'b0;
        @(negedge clk);
        chk("midreset_data", {data3, data2, data1, data0}, 16'h0);
        chk("midreset_err", frame_err, 1'b0);
        chk("midreset_stalled", stalled, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        last_frame = 16'h0;
        scan(3, 9);
        push_frame(4'h1, 4'h3, 4'h5, 4'h9, 1'b0);
        scan(0, 1); scan(1, 3); scan(2, 5);
        drain("postreset_pending");

        // Identical frame repeated
        push_frame(4'h1, 4'h3, 4'h5, 4'h9, 1'b0);
        scan(0, 1); scan(1, 3); scan(2, 5); scan(3, 9);
        drain("same_pending");

        idle(10);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
